tdc_shot_edge_collector: RTL and testbench

//   Per-shot TDC edge collector for NUM_CH receive channels. Sits between the TDC result

---
 rtl/tdc_shot_edge_collector.sv | 180 ++++++++++++++++++
 tb/tb_tdc_shot_edge_collector.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_shot_edge_collector.sv
// Per-shot TDC edge collector: tracks earliest in-range rise/fall per channel
// between laser strobes and publishes one result set per shot.
module tdc_shot_edge_collector #(
  parameter int          NUM_CH    = 4,
  parameter int          CH_ID_W   = 3,
  parameter int          TDC_W     = 19,
  parameter int          DATA_W    = 16,
  parameter int unsigned MAX_RANGE = 20000,
  parameter int          CNT_W     = 4,
  parameter int unsigned TIMEOUT   = 500000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_laser_str,
  input  logic                     i_tdc_edge_id,
  input  logic [CH_ID_W-1:0]       i_tdc_channel_id,
  input  logic                     i_tdc_valid,
  input  logic [TDC_W-1:0]         i_tdc_result,
  output logic [NUM_CH*DATA_W-1:0] o_rise_data,
  output logic [NUM_CH*DATA_W-1:0] o_fall_data,
  output logic [NUM_CH*DATA_W-1:0] o_pulse_width,
  output logic [NUM_CH*CNT_W-1:0]  o_rise_cnt,
  output logic [NUM_CH*CNT_W-1:0]  o_fall_cnt,
  output logic [NUM_CH-1:0]        o_err_flags,
  output logic                     o_data_valid,
  output logic                     o_armed
);

  typedef enum logic {S_IDLE, S_ARMED} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;
  logic   str_d_q;
  logic   str_rise;
  logic   wd_exp;
  logic   publish;
  logic   qual;
  logic [31:0]       wd_q;
  logic [DATA_W-1:0] res_lo;
  logic [NUM_CH-1:0] hit_r, hit_f;
  logic [NUM_CH-1:0] have_r, have_f;

  logic [DATA_W-1:0] rise_q [NUM_CH];
  logic [DATA_W-1:0] fall_q [NUM_CH];
  logic [CNT_W-1:0]  rcnt_q [NUM_CH];
  logic [CNT_W-1:0]  fcnt_q [NUM_CH];

  logic [NUM_CH*DATA_W-1:0] rise_d, fall_d, width_d;
  logic [NUM_CH*CNT_W-1:0]  rcnt_d, fcnt_d;
  logic [NUM_CH-1:0]        err_d;

  assign str_rise = i_laser_str & ~str_d_q;
  assign wd_exp   = (wd_q == TIMEOUT);
  assign res_lo   = i_tdc_result[DATA_W-1:0];
  assign qual     = i_tdc_valid
                  & (32'(i_tdc_channel_id) < 32'(NUM_CH))
                  & (32'(i_tdc_result) < MAX_RANGE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (str_rise) state_d = S_ARMED;
      S_ARMED: if (!str_rise && wd_exp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_armed = (state_q == S_ARMED);
    publish = o_armed & str_rise;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      str_d_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      str_d_q <= i_laser_str;
      if (i_laser_str)  wd_q <= '0;
      else if (!wd_exp) wd_q <= wd_q + 32'd1;
    end
  end

  always_comb begin
    hit_r = '0;
    hit_f = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit_r[c] = qual & i_tdc_edge_id
               & (i_tdc_channel_id == CH_ID_W'(c));
      hit_f[c] = qual & ~i_tdc_edge_id
               & (i_tdc_channel_id == CH_ID_W'(c));
    end
  end

  // A strobe clears the shot, but a coincident hit opens the new one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rise_q[c] <= '0;
        fall_q[c] <= '0;
        rcnt_q[c] <= '0;
        fcnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (str_rise) begin
          rise_q[c] <= hit_r[c] ? res_lo : '0;
          fall_q[c] <= hit_f[c] ? res_lo : '0;
          rcnt_q[c] <= hit_r[c] ? CNT_ONE : '0;
          fcnt_q[c] <= hit_f[c] ? CNT_ONE : '0;
        end else begin
          if (hit_r[c]) begin
            if (rcnt_q[c] == '0 || res_lo < rise_q[c])
              rise_q[c] <= res_lo;
            if (rcnt_q[c] != '1)
              rcnt_q[c] <= rcnt_q[c] + CNT_ONE;
          end
          if (hit_f[c]) begin
            if (fcnt_q[c] == '0 || res_lo < fall_q[c])
              fall_q[c] <= res_lo;
            if (fcnt_q[c] != '1)
              fcnt_q[c] <= fcnt_q[c] + CNT_ONE;
          end
        end
      end
    end
  end

  always_comb begin
    have_r  = '0;
    have_f  = '0;
    rise_d  = '0;
    fall_d  = '0;
    width_d = '0;
    rcnt_d  = '0;
    fcnt_d  = '0;
    err_d   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      have_r[c] = (rcnt_q[c] != '0);
      have_f[c] = (fcnt_q[c] != '0);
      rise_d[c*DATA_W +: DATA_W] = have_r[c] ? rise_q[c] : '0;
      fall_d[c*DATA_W +: DATA_W] = have_f[c] ? fall_q[c] : '0;
      rcnt_d[c*CNT_W +: CNT_W]   = rcnt_q[c];
      fcnt_d[c*CNT_W +: CNT_W]   = fcnt_q[c];
      if (have_r[c] && have_f[c] && fall_q[c] >= rise_q[c])
        width_d[c*DATA_W +: DATA_W] = fall_q[c] - rise_q[c];
      err_d[c] = (have_r[c] ^ have_f[c])
               | (have_r[c] & have_f[c] & (fall_q[c] < rise_q[c]));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data_valid  <= 1'b0;
      o_rise_data   <= '0;
      o_fall_data   <= '0;
      o_pulse_width <= '0;
      o_rise_cnt    <= '0;
      o_fall_cnt    <= '0;
      o_err_flags   <= '0;
    end else begin
      o_data_valid <= publish;
      if (publish) begin
        o_rise_data   <= rise_d;
        o_fall_data   <= fall_d;
        o_pulse_width <= width_d;
        o_rise_cnt    <= rcnt_d;
        o_fall_cnt    <= fcnt_d;
        o_err_flags   <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_tdc_shot_edge_collector.sv
// Randomized scoreboard bench for tdc_shot_edge_collector with a
// shot-level reference model (min/count per channel, plain arithmetic).
module tb_tdc_shot_edge_collector;

  localparam int NUM_CH    = 4;
  localparam int CH_ID_W   = 3;
  localparam int TDC_W     = 19;
  localparam int DATA_W    = 16;
  localparam int MAX_RANGE = 20000;
  localparam int CNT_W     = 4;
  localparam int TIMEOUT   = 1000;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                     i_clk = 1'b0;
  logic                     i_rst;
  logic                     i_laser_str;
  logic                     i_tdc_edge_id;
  logic [CH_ID_W-1:0]       i_tdc_channel_id;
  logic                     i_tdc_valid;
  logic [TDC_W-1:0]         i_tdc_result;
  logic [NUM_CH*DATA_W-1:0] o_rise_data;
  logic [NUM_CH*DATA_W-1:0] o_fall_data;
  logic [NUM_CH*DATA_W-1:0] o_pulse_width;
  logic [NUM_CH*CNT_W-1:0]  o_rise_cnt;
  logic [NUM_CH*CNT_W-1:0]  o_fall_cnt;
  logic [NUM_CH-1:0]        o_err_flags;
  logic                     o_data_valid;
  logic                     o_armed;

  tdc_shot_edge_collector #(
    .NUM_CH(NUM_CH), .CH_ID_W(CH_ID_W), .TDC_W(TDC_W),
    .DATA_W(DATA_W), .MAX_RANGE(MAX_RANGE), .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_laser_str(i_laser_str),
    .i_tdc_edge_id(i_tdc_edge_id),
    .i_tdc_channel_id(i_tdc_channel_id),
    .i_tdc_valid(i_tdc_valid), .i_tdc_result(i_tdc_result),
    .o_rise_data(o_rise_data), .o_fall_data(o_fall_data),
    .o_pulse_width(o_pulse_width), .o_rise_cnt(o_rise_cnt),
    .o_fall_cnt(o_fall_cnt), .o_err_flags(o_err_flags),
    .o_data_valid(o_data_valid), .o_armed(o_armed)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NUM_CH*DATA_W-1:0] rise;
    logic [NUM_CH*DATA_W-1:0] fall;
    logic [NUM_CH*DATA_W-1:0] width;
    logic [NUM_CH*CNT_W-1:0]  rc;
    logic [NUM_CH*CNT_W-1:0]  fc;
    logic [NUM_CH-1:0]        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit m_armed;
  bit m_prev;
  int m_low;
  int m_rn [NUM_CH];
  int m_fn [NUM_CH];
  int m_rmin [NUM_CH];
  int m_fmin [NUM_CH];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic void m_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_rn[c] = 0; m_fn[c] = 0;
      m_rmin[c] = 0; m_fmin[c] = 0;
    end
  endfunction

  function automatic void m_publish();
    exp_t e;
    int r, f, rc, fc;
    e = '{default: '0};
    for (int c = 0; c < NUM_CH; c++) begin
      rc = (m_rn[c] > CNT_MAX) ? CNT_MAX : m_rn[c];
      fc = (m_fn[c] > CNT_MAX) ? CNT_MAX : m_fn[c];
      r  = (m_rn[c] > 0) ? m_rmin[c] : 0;
      f  = (m_fn[c] > 0) ? m_fmin[c] : 0;
      e.rise[c*DATA_W +: DATA_W] = DATA_W'(r);
      e.fall[c*DATA_W +: DATA_W] = DATA_W'(f);
      e.rc[c*CNT_W +: CNT_W] = CNT_W'(rc);
      e.fc[c*CNT_W +: CNT_W] = CNT_W'(fc);
      if (rc > 0 && fc > 0 && f >= r)
        e.width[c*DATA_W +: DATA_W] = DATA_W'(f - r);
      e.err[c] = ((rc > 0) != (fc > 0)) ||
                 (rc > 0 && fc > 0 && f < r);
    end
    exp_q.push_back(e);
  endfunction

  function automatic void model_step(bit str, bit v, bit e,
                                     int ch, int res);
    if (str && !m_prev) begin
      if (m_armed) m_publish();
      m_armed = 1;
      m_clear();
    end else if (m_armed && m_low == TIMEOUT) begin
      m_armed = 0;
    end
    m_low  = str ? 0 : ((m_low < TIMEOUT) ? m_low + 1 : TIMEOUT);
    m_prev = str;
    if (v && ch < NUM_CH && res < MAX_RANGE) begin
      if (e) begin
        if (m_rn[ch] == 0 || res < m_rmin[ch]) m_rmin[ch] = res;
        m_rn[ch]++;
      end else begin
        if (m_fn[ch] == 0 || res < m_fmin[ch]) m_fmin[ch] = res;
        m_fn[ch]++;
      end
    end
  endfunction

  task automatic step(bit str, bit v, bit e, int ch, int res);
    i_laser_str      = str;
    i_tdc_valid      = v;
    i_tdc_edge_id    = e;
    i_tdc_channel_id = CH_ID_W'(ch);
    i_tdc_result     = TDC_W'(res);
    model_step(str, v, e, ch, res);
    @(posedge i_clk);
    #1;
    chk("armed", 64'(o_armed), 64'(m_armed));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic hit(bit e, int ch, int res);
    step(0, 1, e, ch, res);
  endtask

  task automatic strobe_hi();
    step(1, 0, 0, 0, 0);
  endtask

  task automatic strobe();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    i_rst = 1;
    i_laser_str = 0;
    i_tdc_valid = 0;
    m_armed = 0; m_prev = 0; m_low = 0;
    m_clear();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 0;
  endtask

  // Scoreboard monitor: sample between active edges
  always @(negedge i_clk) begin
    if (!i_rst && o_data_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL valid: unexpected o_data_valid=1, expected 0 (t=%0t)",
                 $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rise_data",   64'(o_rise_data),   64'(mon_e.rise));
        chk("fall_data",   64'(o_fall_data),   64'(mon_e.fall));
        chk("pulse_width", 64'(o_pulse_width), 64'(mon_e.width));
        chk("rise_cnt",    64'(o_rise_cnt),    64'(mon_e.rc));
        chk("fall_cnt",    64'(o_fall_cnt),    64'(mon_e.fc));
        chk("err_flags",   64'(o_err_flags),   64'(mon_e.err));
      end
    end
  end

  initial begin
    int ch, res, len, hold;
    bit e;
    i_tdc_edge_id = 0;
    i_tdc_channel_id = '0;
    i_tdc_result = '0;
    do_reset();

    chk("rst_rise",  64'(o_rise_data),   64'd0);
    chk("rst_fall",  64'(o_fall_data),   64'd0);
    chk("rst_width", 64'(o_pulse_width), 64'd0);
    chk("rst_rcnt",  64'(o_rise_cnt),    64'd0);
    chk("rst_fcnt",  64'(o_fall_cnt),    64'd0);
    chk("rst_err",   64'(o_err_flags),   64'd0);
    chk("rst_valid", 64'(o_data_valid),  64'd0);
    chk("rst_armed", 64'(o_armed),       64'd0);

    // Basic shot on ch0
    strobe();
    hit(1, 0, 100);
    hit(0, 0, 150);
    idle(2);
    strobe_hi();
    chk("t1_valid", 64'(o_data_valid), 64'd1);
    chk("t1_rise0", 64'(o_rise_data[15:0]), 64'd100);
    chk("t1_fall0", 64'(o_fall_data[15:0]), 64'd150);
    chk("t1_wid0",  64'(o_pulse_width[15:0]), 64'd50);
    chk("t1_rc",    64'(o_rise_cnt), 64'h0001);
    idle(1);
    chk("t1_pulse", 64'(o_data_valid), 64'd0);

    // Earliest rise with duplicates, no fall
    hit(1, 1, 300); hit(1, 1, 120); hit(1, 1, 120); hit(1, 1, 200);
    strobe_hi();
    chk("t2_rise1", 64'(o_rise_data[31:16]), 64'd120);
    chk("t2_rc1",   64'(o_rise_cnt[7:4]), 64'd4);
    chk("t2_err1",  64'(o_err_flags[1]), 64'd1);
    idle(1);

    // Out-of-range and bad channel ignored; range boundary
    hit(1, 2, 25000); hit(1, 7, 50);
    hit(1, 0, MAX_RANGE); hit(0, 0, MAX_RANGE - 1);
    strobe_hi();
    chk("t3_rc2",  64'(o_rise_cnt[11:8]), 64'd0);
    chk("t3_err2", 64'(o_err_flags[2]), 64'd0);
    chk("t3_fc0",  64'(o_fall_cnt[3:0]), 64'd1);
    idle(1);

    // Counter saturation
    for (int i = 0; i < 20; i++) hit(1, 0, $urandom_range(0, 19999));
    strobe_hi();
    chk("t4_sat", 64'(o_rise_cnt[3:0]), 64'd15);
    idle(1);

    // Hit coincident with strobe opens the next shot
    step(1, 1, 1, 3, 500);
    chk("t5_cnt0", 64'(o_rise_cnt[15:12]), 64'd0);
    idle(2);
    strobe_hi();
    chk("t5_cnt1", 64'(o_rise_cnt[15:12]), 64'd1);
    idle(1);

    // Watchdog disarm
    idle(TIMEOUT + 20);
    chk("t6_disarm", 64'(o_armed), 64'd0);
    hit(1, 2, 77);
    strobe_hi();
    chk("t6_novalid", 64'(o_data_valid), 64'd0);
    idle(1);
    hit(0, 2, 90);
    strobe_hi();
    chk("t6_valid", 64'(o_data_valid), 64'd1);
    idle(1);

    // Reset mid-shot
    hit(1, 1, 10); hit(0, 1, 20);
    do_reset();
    chk("t7_armed", 64'(o_armed), 64'd0);
    strobe();
    hit(0, 1, 40); hit(1, 1, 60);
    strobe();

    // Randomized shots
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(3, 25);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          ch = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7)
                                           : $urandom_range(0, 3);
          case ($urandom_range(0, 5))
            0:       res = MAX_RANGE - 1;
            1:       res = MAX_RANGE;
            2:       res = $urandom_range(0, 20);
            default: res = $urandom_range(0, 20500);
          endcase
          e = 1'($urandom_range(0, 1));
          hit(e, ch, res);
        end else begin
          idle(1);
        end
      end
      hold = $urandom_range(1, 3);
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 3) == 0)
          step(1, 1, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 19999));
        else
          step(1, 0, 0, 0, 0);
      end
    end
    strobe();

    idle(3);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
